rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: a_valid input 1, a_addr input 6, a_data input 32, a_ready output 1  ALU write-back requester.
REQ-004 SHALL have ports: b_valid input 1, b_addr input 6, b_data input 32, b_ready output 1  load-unit write-back requester.
REQ-005 SHALL have ports: wr_en output 1, wr_addr output 6, wr_data output 32  to the register-file write port.
REQ-006 SHALL have ports: rsv_valid input 1, rsv_addr input 6  reserve a destination register at issue.
REQ-007 SHALL have ports: q1addr input 6, q2addr input 6, q1busy output 1, q2busy output 1  scoreboard query for the two read addresses.
REQ-008 SHALL have port: flush input 1  drops the current cycle's grant and clears the scoreboard.

Function
REQ-009 SHALL hold state: prio (1 bit, 0 = A preferred, 1 = B preferred), busy[63:0], and registered wr_en/wr_addr/wr_data.
REQ-010 SHALL compute grants combinationally: with flush=1 neither is granted; only A valid -> A; only B valid -> B; both valid -> the requester selected by prio.
REQ-011 SHALL drive a_ready = grant_A and b_ready = grant_B; at most one is 1 per cycle; the handshake completes when valid & ready.
REQ-012 SHALL update prio after each completed handshake to point to the requester not granted; with no grant, prio holds.
REQ-013 SHALL register the granted request: at the next edge, wr_en=1 and wr_addr/wr_data = the granted addr/data, giving a latency of 1 cycle from handshake to the write port.
REQ-014 SHALL set wr_en=0 at the next edge when no grant occurs; wr_addr/wr_data hold their previous values.
REQ-015 SHALL clear busy[addr] at the edge ending a completed handshake for that addr.
REQ-016 SHALL set busy[rsv_addr] at the edge when rsv_valid=1 and flush=0.
REQ-017 SHALL give set priority over clear when a reservation and a granted write target the same address in the same cycle, leaving busy=1.
REQ-018 SHALL treat reservation of an already-busy register as a no-op (single bit, no count); one write clears it.
REQ-019 SHALL leave busy unchanged by a write to a non-busy register, while the write is still forwarded.
REQ-020 SHALL drive q1busy = busy[q1addr] and q2busy = busy[q2addr] combinationally from registered state only (no same-cycle bypass).
REQ-021 SHALL, with flush=1, clear all busy bits and set wr_en=0 at the next edge, ignore rsv_valid, and hold prio.
REQ-022 SHALL apply no special handling to address 0.

Reset
REQ-023 SHALL, with rst=1 at an edge, set wr_en=0, wr_addr=0, wr_data=0, busy=0, prio=0; rst overrides flush and all requests.
REQ-024 SHALL drive a_ready=b_ready=0 while rst=1, including when asserted mid-transfer; a registered write pending at the reset edge is discarded.

Verification
REQ-025 SHALL check single requester: after reset, a_valid=1, a_addr=5, a_data=36 for 1 cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=36; following cycle wr_en=0.
REQ-026 SHALL check contention: A(1,63) and B(2,69) held valid from reset -> grants A, B, A, B in consecutive cycles; wr_en=1 on every cycle after the first.
REQ-027 SHALL check scoreboard: rsv 1 -> q1addr=1 gives q1busy=1 next cycle; B writes reg 1 -> q1busy=0 the cycle after the handshake.
REQ-028 SHALL check same-cycle conflict: busy[3]=1, with rsv_addr=3 and A write to 3 in one cycle -> busy[3] remains 1.
REQ-029 SHALL check flush: busy[1], busy[5] set, flush=1 with A valid -> a_ready=0; next cycle wr_en=0, q1busy=q2busy=0 for addresses 1 and 5.
REQ-030 SHALL check reset mid-operation: rst=1 while A and B are valid and wr_en=1 -> next cycle all outputs 0 and prio=0 (A granted first after release).

Source files
------------

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Arbitrates two write-back requesters (ALU = A, load unit = B) onto the
// single register-file write port and keeps a busy scoreboard of destination
// registers that have been reserved at issue but not yet written back.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready  ALU write-back request channel
//   b_valid/b_addr/b_data/b_ready  load-unit write-back request channel
//   wr_en/wr_addr/wr_data          registered register-file write port
//   rsv_valid/rsv_addr             reserve a destination register at issue
//   q1addr/q2addr, q1busy/q2busy   scoreboard lookup for two read operands
//   flush                          drop this cycle's grant, clear scoreboard
// ---------------------------------------------------------------------------
module rf_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [5:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [5:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        rsv_valid,
  input  logic [5:0]  rsv_addr,
  input  logic [5:0]  q1addr,
  input  logic [5:0]  q2addr,
  output logic        q1busy,
  output logic        q2busy,
  input  logic        flush
);

  // prio = 0 prefers A on contention, 1 prefers B.
  logic        prio;
  logic [63:0] busy;
  logic [63:0] busy_next;
  logic        grant_a;
  logic        grant_b;

  // Grant decision. Reset and flush suppress both grants so that neither
  // requester sees a handshake that would then be dropped.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !flush) begin
      if (a_valid && (!b_valid || !prio)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Lookups read registered state only; a reservation or write in the same
  // cycle becomes visible after the edge.
  assign q1busy = busy[q1addr];
  assign q2busy = busy[q2addr];

  // Next scoreboard: the write-back clear is applied first and the
  // reservation set last, so a same-cycle reserve of the written register
  // leaves it busy (the new producer still owes a result).
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (grant_a) busy_next[a_addr] = 1'b0;
      if (grant_b) busy_next[b_addr] = 1'b0;
      if (rsv_valid) busy_next[rsv_addr] = 1'b1;
    end
  end

  // State update: priority toggles toward the loser after each handshake,
  // and the granted request is forwarded to the write port one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio    <= 1'b0;
      busy    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      busy  <= busy_next;
      wr_en <= grant_a | grant_b;
      if (grant_a) begin
        prio    <= 1'b1;
        wr_addr <= a_addr;
        wr_data <= a_data;
      end else if (grant_b) begin
        prio    <= 1'b0;
        wr_addr <= b_addr;
        wr_data <= b_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Self-checking bench for rf_write_arbiter. A behavioural model (an array of
// pending registers, a "who goes next" flag and the last forwarded write)
// predicts every output; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [5:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [5:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_valid;
  logic [5:0]  rsv_addr;
  logic [5:0]  q1addr;
  logic [5:0]  q2addr;
  logic        q1busy;
  logic        q2busy;
  logic        flush;

  int compared;
  int mismatched;

  // Reference model state
  bit          pending [64];
  bit          nextIsB;
  bit          mWe;
  logic [5:0]  mAddr;
  logic [31:0] mData;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q1addr(q1addr), .q2addr(q2addr), .q1busy(q1busy), .q2busy(q2busy),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Who wins this cycle: 0 nobody, 1 = A, 2 = B.
  function automatic int winner();
    if (rst || flush) return 0;
    if (a_valid && b_valid) return nextIsB ? 2 : 1;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit fl,
                               input bit av, input logic [5:0] aa, input logic [31:0] ad,
                               input bit bv, input logic [5:0] ba, input logic [31:0] bd,
                               input bit rv, input logic [5:0] ra,
                               input logic [5:0] qa, input logic [5:0] qb);
    rst = r; flush = fl;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    rsv_valid = rv; rsv_addr = ra;
    q1addr = qa; q2addr = qb;
    #1;
  endtask

  // Compare every output with the model, then clock one edge and advance
  // the model using the same inputs.
  task automatic checkOutput(input string tag);
    int w;
    w = winner();
    chk({tag, ".a_ready"}, a_ready, w == 1);
    chk({tag, ".b_ready"}, b_ready, w == 2);
    chk({tag, ".wr_en"},   wr_en,   mWe);
    chk({tag, ".wr_addr"}, wr_addr, mAddr);
    chk({tag, ".wr_data"}, wr_data, mData);
    chk({tag, ".q1busy"},  q1busy,  pending[q1addr]);
    chk({tag, ".q2busy"},  q2busy,  pending[q2addr]);
    @(posedge clk);
    if (rst) begin
      foreach (pending[i]) pending[i] = 1'b0;
      nextIsB = 1'b0; mWe = 1'b0; mAddr = '0; mData = '0;
    end else if (flush) begin
      foreach (pending[i]) pending[i] = 1'b0;
      mWe = 1'b0;
    end else begin
      mWe = (w != 0);
      if (w == 1) begin
        pending[a_addr] = 1'b0; mAddr = a_addr; mData = a_data; nextIsB = 1'b1;
      end else if (w == 2) begin
        pending[b_addr] = 1'b0; mAddr = b_addr; mData = b_data; nextIsB = 1'b0;
      end
      if (rsv_valid) pending[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, q1addr, q2addr);
    checkOutput(tag);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset");
  endtask

  initial begin
    compared = 0; mismatched = 0;
    foreach (pending[i]) pending[i] = 1'b0;
    nextIsB = 1'b0; mWe = 1'b0; mAddr = '0; mData = '0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    doReset();
    chk("rst.wr_en", wr_en, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);

    // Single requester: A writes 36 to register 5.
    applyStimulus(0, 0, 1, 6'd5, 32'd36, 0, 0, 0, 0, 0, 0, 0);
    chk("single.a_ready", a_ready, 1);
    checkOutput("single.req");
    chk("single.wr_en", wr_en, 1);
    chk("single.wr_addr", wr_addr, 5);
    chk("single.wr_data", wr_data, 36);
    idle("single.gap");
    chk("single.wr_en_off", wr_en, 0);
    idle("single.idle");

    // Contention: alternating grants starting with A after reset.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 6'd1, 32'd63, 1, 6'd2, 32'd69, 0, 0, 0, 0);
      chk("cont.a_ready", a_ready, (i % 2) == 0);
      chk("cont.b_ready", b_ready, (i % 2) == 1);
      if (i > 0) chk("cont.wr_en", wr_en, 1);
      checkOutput("cont");
    end
    idle("cont.drain");

    // Scoreboard: reserve 1, observe busy, B writes 1, busy clears.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd1, 6'd1, 6'd0);
    chk("sb.q1busy_same", q1busy, 0);
    checkOutput("sb.rsv");
    applyStimulus(0, 0, 0, 0, 0, 1, 6'd1, 32'hABCD, 0, 0, 6'd1, 6'd0);
    chk("sb.q1busy_set", q1busy, 1);
    checkOutput("sb.write");
    chk("sb.q1busy_clr", q1busy, 0);
    idle("sb.idle");

    // Same-cycle reserve and write of register 3 leaves it busy.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd3, 6'd3, 6'd0);
    checkOutput("conf.rsv");
    applyStimulus(0, 0, 1, 6'd3, 32'h33, 0, 0, 0, 1, 6'd3, 6'd3, 6'd0);
    checkOutput("conf.both");
    chk("conf.q1busy", q1busy, 1);
    idle("conf.idle");

    // Flush with A valid: no grant, scoreboard cleared.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd1, 6'd1, 6'd5);
    checkOutput("fl.rsv1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd5, 6'd1, 6'd5);
    checkOutput("fl.rsv5");
    applyStimulus(0, 1, 1, 6'd7, 32'h77, 0, 0, 0, 1, 6'd9, 6'd1, 6'd5);
    chk("fl.a_ready", a_ready, 0);
    chk("fl.q2busy_before", q2busy, 1);
    checkOutput("fl.flush");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd1, 6'd5);
    chk("fl.wr_en", wr_en, 0);
    chk("fl.q1busy", q1busy, 0);
    chk("fl.q2busy", q2busy, 0);
    checkOutput("fl.after");

    // Reset mid-operation while both requesters are active.
    applyStimulus(0, 0, 1, 6'd10, 32'h1010, 1, 6'd11, 32'h1111, 1, 6'd4, 6'd4, 6'd10);
    checkOutput("mid.run0");
    applyStimulus(0, 0, 1, 6'd10, 32'h1010, 1, 6'd11, 32'h1111, 0, 0, 6'd4, 6'd10);
    chk("mid.wr_en_on", wr_en, 1);
    checkOutput("mid.run1");
    applyStimulus(1, 0, 1, 6'd10, 32'h1010, 1, 6'd11, 32'h1111, 1, 6'd12, 6'd4, 6'd12);
    chk("mid.a_ready_rst", a_ready, 0);
    chk("mid.b_ready_rst", b_ready, 0);
    checkOutput("mid.rst");
    applyStimulus(0, 0, 1, 6'd10, 32'h1010, 1, 6'd11, 32'h1111, 0, 0, 6'd4, 6'd12);
    chk("mid.wr_en0", wr_en, 0);
    chk("mid.wr_addr0", wr_addr, 0);
    chk("mid.wr_data0", wr_data, 0);
    chk("mid.q1busy0", q1busy, 0);
    chk("mid.a_first", a_ready, 1);
    checkOutput("mid.release");
    idle("mid.idle");

    // Random traffic over a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(63) == 0, $urandom_range(15) == 0,
                    $urandom_range(1), 6'($urandom_range(7)), $urandom,
                    $urandom_range(1), 6'($urandom_range(7)), $urandom,
                    $urandom_range(2) == 0,
                    ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(7)),
                    6'($urandom_range(7)), 6'($urandom_range(63)));
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
